// File: rtl/alu_arbiter.sv
// Shares one registered ALU (1-cycle latency) among NUM_REQ requesters and returns held results.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index) instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data_o,
  output logic [OP_W-1:0]           alu_op_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  input  logic [DATA_W-1:0]         alu_result_i
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                inflight_reg;
  logic [ID_W-1:0]     owner_reg;
  logic [ID_W-1:0]     ptr_start;
  logic [NUM_REQ-1:0]  eligible;
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic                issue;

  logic [OP_W-1:0]     op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];

  // Per-requester unpacking, eligibility, handshake and held response register
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;
      logic              is_owner;

      assign op_arr[gi] = req_op_i[gi*OP_W +: OP_W];
      assign a_arr[gi]  = req_a_i[gi*DATA_W +: DATA_W];
      assign b_arr[gi]  = req_b_i[gi*DATA_W +: DATA_W];

      assign is_owner     = inflight_reg && (owner_reg == ID_W'(gi));
      assign eligible[gi] = req_valid_i[gi] & ~valid_reg & ~is_owner;
      assign req_ready_o[gi] = issue && (grant_id == ID_W'(gi));

      // Capture and consume never collide: an owner cannot hold a pending response.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (is_owner) begin
          valid_reg <= 1'b1;
          data_reg  <= alu_result_i;
        end else if (valid_reg && rsp_ready_i[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign rsp_valid_o[gi]                 = valid_reg;
      assign rsp_data_o[gi*DATA_W +: DATA_W] = data_reg;
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr_start = '0;
`else
  logic [ID_W-1:0] ptr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (issue) begin
      ptr_reg <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  assign ptr_start = ptr_reg;
`endif

  // Search eligible requesters starting at ptr_start, wrapping modulo NUM_REQ
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_start) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Outputs stay quiet while reset is held, even if requests are already valid
  assign issue = grant_found & ~reset;

  always_comb begin
    alu_op_o = '0;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (issue) begin
      alu_op_o = op_arr[grant_id];
      alu_a_o  = a_arr[grant_id];
      alu_b_o  = b_arr[grant_id];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg <= 1'b0;
      owner_reg    <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        owner_reg <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter with a behavioural registered ALU.
// Expected grant orders depend on ALU_ARB_FIXED_PRIO_EN where the two policies differ.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [7:0]    req_op = '0;
  logic [63:0]   req_a = '0;
  logic [63:0]   req_b = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = '0;
  logic [63:0]   rsp_data;
  logic [3:0]    alu_op;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [31:0]   alu_result = '0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.NUM_REQ(2), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    bit          pre_reset;
    logic [1:0]  valid;
    logic [1:0]  rrdy;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit r, input logic [1:0] val, input logic [1:0] rr,
                              input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [1:0] er, input logic [1:0] ev,
                              input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.pre_reset = r;  v.valid = val; v.rrdy = rr;
    v.op0 = o0; v.a0 = a0; v.b0 = b0;
    v.op1 = o1; v.a1 = a1; v.b1 = b1;
    v.exp_ready = er; v.exp_rv = ev; v.exp_d0 = d0; v.exp_d1 = d1;
    return v;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check("reset ready", 72'(req_ready), 72'd0);
    check("reset rsp_valid", 72'(rsp_valid), 72'd0);
    check("reset rsp_data", 72'(rsp_data), 72'd0);
    check("reset alu", {alu_op, alu_a, alu_b}, 72'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [71:0] exp_alu;
    // Test 1: single ADD, latency N+2, held until consumed
    vecs.push_back(mk(1, 2'b01, 2'b00, OP_ADD, 3, 4, OP_ADD, 0, 0, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b01, 7, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b01, 7, 0));
    vecs.push_back(mk(0, 2'b00, 2'b01, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b01, 7, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b00, 0, 0));
    // Tests 2/3: simultaneous AND/XOR, then req0 blocked by its unconsumed response
    vecs.push_back(mk(1, 2'b11, 2'b00, OP_AND, 19, 21, OP_XOR, 19, 21, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b10, 2'b00, OP_AND, 19, 21, OP_XOR, 19, 21, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b01, 17, 0));
    vecs.push_back(mk(0, 2'b01, 2'b10, OP_ADD, 5, 6, OP_ADD, 0, 0, 2'b00, 2'b11, 17, 6));
    vecs.push_back(mk(0, 2'b11, 2'b00, OP_ADD, 5, 6, OP_SUB, 100, 30, 2'b10, 2'b01, 17, 0));
    vecs.push_back(mk(0, 2'b01, 2'b00, OP_ADD, 5, 6, OP_ADD, 0, 0, 2'b00, 2'b01, 17, 0));
    vecs.push_back(mk(0, 2'b01, 2'b10, OP_ADD, 5, 6, OP_ADD, 0, 0, 2'b00, 2'b11, 17, 70));
    vecs.push_back(mk(0, 2'b11, 2'b00, OP_ADD, 5, 6, OP_OR, 32'hF0, 32'h0F, 2'b10, 2'b01, 17, 0));
    vecs.push_back(mk(0, 2'b01, 2'b00, OP_ADD, 5, 6, OP_ADD, 0, 0, 2'b00, 2'b01, 17, 0));
    vecs.push_back(mk(0, 2'b01, 2'b11, OP_ADD, 5, 6, OP_ADD, 0, 0, 2'b00, 2'b11, 17, 255));
    vecs.push_back(mk(0, 2'b01, 2'b00, OP_ADD, 5, 6, OP_ADD, 0, 0, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b01, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b01, 11, 0));
    // Both eligible with the round-robin pointer at 1: policies diverge here
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_AND, 32'hFF, 32'h3C, OP_ADD, 1, 2,
                      FIXED ? 2'b01 : 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_AND, 32'hFF, 32'h3C, OP_ADD, 1, 2,
                      FIXED ? 2'b10 : 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b11, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00,
                      FIXED ? 2'b01 : 2'b10, 32'h3C, 3));
    vecs.push_back(mk(0, 2'b00, 2'b11, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00,
                      FIXED ? 2'b10 : 2'b01, 32'h3C, 3));
    vecs.push_back(mk(0, 2'b00, 2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b00, 0, 0));
    // Tests 4/6: both valid continuously, all responses consumed immediately
    vecs.push_back(mk(1, 2'b11, 2'b11, OP_ADD, 10, 20, OP_SUB, 50, 8, 2'b01, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_OR, 32'h100, 32'h011, OP_SUB, 50, 8, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_OR, 32'h100, 32'h011, OP_XOR, 32'hAAAA, 32'h5555, 2'b00, 2'b01, 30, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_OR, 32'h100, 32'h011, OP_XOR, 32'hAAAA, 32'h5555, 2'b01, 2'b10, 0, 42));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_SUB, 7, 9, OP_XOR, 32'hAAAA, 32'h5555, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_SUB, 7, 9, OP_AND, 32'hF0F0, 32'hFF00, 2'b00, 2'b01, 32'h111, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_SUB, 7, 9, OP_AND, 32'hF0F0, 32'hFF00, 2'b01, 2'b10, 0, 32'hFFFF));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_ADD, 32'hFFFFFFFF, 1, OP_AND, 32'hF0F0, 32'hFF00, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_ADD, 32'hFFFFFFFF, 1, OP_AND, 32'hF0F0, 32'hFF00, 2'b00, 2'b01, 32'hFFFFFFFE, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, OP_ADD, 32'hFFFFFFFF, 1, OP_AND, 32'hF0F0, 32'hFF00, 2'b01, 2'b10, 0, 32'hF000));
    vecs.push_back(mk(0, 2'b00, 2'b11, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b11, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b01, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b11, OP_ADD, 0, 0, OP_ADD, 0, 0, 2'b00, 2'b00, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_reset) do_reset();
      req_valid = vecs[i].valid;
      rsp_ready = vecs[i].rrdy;
      req_op    = {vecs[i].op1, vecs[i].op0};
      req_a     = {vecs[i].a1, vecs[i].a0};
      req_b     = {vecs[i].b1, vecs[i].b0};
      #4;
      check($sformatf("vec%0d ready", i), 72'(req_ready), 72'(vecs[i].exp_ready));
      check($sformatf("vec%0d rsp_valid", i), 72'(rsp_valid), 72'(vecs[i].exp_rv));
      if (vecs[i].exp_ready == 2'b01)      exp_alu = {vecs[i].op0, vecs[i].a0, vecs[i].b0};
      else if (vecs[i].exp_ready == 2'b10) exp_alu = {vecs[i].op1, vecs[i].a1, vecs[i].b1};
      else                                 exp_alu = '0;
      check($sformatf("vec%0d alu", i), {alu_op, alu_a, alu_b}, exp_alu);
      if (vecs[i].exp_rv[0]) check($sformatf("vec%0d rsp_data0", i), 72'(rsp_data[31:0]), 72'(vecs[i].exp_d0));
      if (vecs[i].exp_rv[1]) check($sformatf("vec%0d rsp_data1", i), 72'(rsp_data[63:32]), 72'(vecs[i].exp_d1));
      @(posedge clk); #1;
    end

    // Test 5: reset during the compute cycle discards the in-flight ADD
    do_reset();
    req_valid = 2'b01; req_op = {4'd0, OP_ADD}; req_a = {32'd0, 32'd3}; req_b = {32'd0, 32'd4};
    #4;
    check("t5 issue ready", 72'(req_ready), 72'b01);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    #2;
    check("t5 rst rsp_valid", 72'(rsp_valid), 72'd0);
    check("t5 rst alu", {alu_op, alu_a, alu_b}, 72'd0);
    @(posedge clk); #1;
    check("t5 rst hold rsp_valid", 72'(rsp_valid), 72'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #4;
      check($sformatf("t5 no rsp c%0d", c), 72'(rsp_valid), 72'd0);
      @(posedge clk); #1;
    end
    req_valid = 2'b11;
    req_op = {OP_ADD, OP_SUB}; req_a = {32'd1, 32'd9}; req_b = {32'd1, 32'd4};
    #4;
    check("t5 first grant", 72'(req_ready), 72'b01);
    check("t5 first alu", {alu_op, alu_a, alu_b}, {OP_SUB, 32'd9, 32'd4});
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    #4;
    check("t5 post rsp_valid", 72'(rsp_valid), 72'b01);
    check("t5 post rsp_data0", 72'(rsp_data[31:0]), 72'd5);
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    #4;
    check("t5 post cleared", 72'(rsp_valid), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
